// File: rtl/axis_key_decoder.sv
// Envelope-to-key decoder: hysteresis threshold plus consecutive-sample debounce,
// logging one run-length record per key transition into a BRAM ring buffer.
module axis_key_decoder #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int HOLD_WIDTH       = 16,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0]  cfg_thr_hi,
    input  logic [AXIS_TDATA_WIDTH-1:0]  cfg_thr_lo,
    input  logic [HOLD_WIDTH-1:0]        cfg_hold,
    output logic                         key_flag,
    output logic [BRAM_ADDR_WIDTH-1:0]   sts_data,
    input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic                         b_bram_clk,
    output logic                         b_bram_rst,
    output logic                         b_bram_en,
    output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata
);

    localparam int RUN_W = BRAM_DATA_WIDTH - 1;
    localparam int WE_W  = BRAM_DATA_WIDTH / 8;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic                       key_q,     key_d;
    logic [HOLD_WIDTH-1:0]      pending_q, pending_d;
    logic [RUN_W-1:0]           run_q,     run_d;
    logic [BRAM_ADDR_WIDTH-1:0] wptr_q,    wptr_d;
    logic [BRAM_ADDR_WIDTH-1:0] sts_q,     sts_d;
    logic                       we_q,      we_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [BRAM_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                       tready_q,  tready_d;

    logic             accept;
    logic             qualifies;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        key_d     = key_q;
        pending_d = pending_q;
        run_d     = run_q;
        wptr_d    = wptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        tready_d  = 1'b1;
        // The reported pointer trails the write pointer by one cycle, so it
        // only advances once the corresponding write has been presented.
        sts_d     = wptr_q;

        accept    = s_axis_tvalid & tready_q;
        qualifies = key_q ? (s_axis_tdata < cfg_thr_lo) : (s_axis_tdata >= cfg_thr_hi);
        run_inc   = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);

        if (accept) begin
            if (qualifies && (pending_q >= cfg_hold)) begin
                // The transitioning sample opens the new run, hence run restarts at 1.
                key_d     = ~key_q;
                pending_d = '0;
                run_d     = RUN_W'(1);
                we_d      = 1'b1;
                addr_d    = wptr_q;
                wdata_d   = {key_q, run_q};
                wptr_d    = wptr_q + BRAM_ADDR_WIDTH'(1);
            end else if (qualifies) begin
                pending_d = pending_q + HOLD_WIDTH'(1);
                run_d     = run_inc;
            end else begin
                pending_d = '0;
                run_d     = run_inc;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            key_q     <= 1'b0;
            pending_q <= '0;
            run_q     <= '0;
            wptr_q    <= '0;
            sts_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tready_q  <= 1'b0;
        end else begin
            key_q     <= key_d;
            pending_q <= pending_d;
            run_q     <= run_d;
            wptr_q    <= wptr_d;
            sts_q     <= sts_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tready_q  <= tready_d;
        end
    end

    assign key_flag      = key_q;
    assign sts_data      = sts_q;
    assign s_axis_tready = tready_q;
    assign b_bram_clk    = aclk;
    assign b_bram_rst    = ~aresetn;
    assign b_bram_we     = {WE_W{we_q}};
    assign b_bram_en     = b_bram_we[0];
    assign b_bram_addr   = addr_q;
    assign b_bram_wdata  = wdata_q;

endmodule

// File: tb/tb_axis_key_decoder.sv
// Bench for axis_key_decoder: directed scenarios plus randomized streams checked
// against a sample-history reference model.
module tb_axis_key_decoder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] cfg_thr_hi = 16'd1000, cfg_thr_lo = 16'd500, cfg_hold = 16'd0;
    logic [15:0] s_axis_tdata = 16'd0;
    logic        s_axis_tvalid = 1'b0;

    logic        key0, tready0, bclk0, brst0, en0;
    logic [9:0]  sts0, addr0;
    logic [3:0]  we0;
    logic [31:0] wdata0;
    logic        key1, tready1, bclk1, brst1, en1;
    logic [1:0]  sts1, addr1;
    logic [3:0]  we1;
    logic [31:0] wdata1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { int cyc; logic [9:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic [31:0] data; } rec_t;
    wr_t  obs0[$];
    wr_t  obs1[$];
    rec_t exp_q[$];

    // Reference model: key state plus the qualify history of the current run.
    bit m_key;
    bit m_hist[$];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axis_key_decoder #(.BRAM_ADDR_WIDTH(10)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo),
        .cfg_hold(cfg_hold), .key_flag(key0), .sts_data(sts0), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready0), .b_bram_clk(bclk0),
        .b_bram_rst(brst0), .b_bram_en(en0), .b_bram_we(we0), .b_bram_addr(addr0),
        .b_bram_wdata(wdata0));

    axis_key_decoder #(.BRAM_ADDR_WIDTH(2)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo),
        .cfg_hold(cfg_hold), .key_flag(key1), .sts_data(sts1), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready1), .b_bram_clk(bclk1),
        .b_bram_rst(brst1), .b_bram_en(en1), .b_bram_we(we1), .b_bram_addr(addr1),
        .b_bram_wdata(wdata1));

    always @(negedge aclk) begin
        if (we0 == 4'hF && en0) obs0.push_back('{cyc, addr0, wdata0});
        if (we1 == 4'hF && en1) obs1.push_back('{cyc, 10'(addr1), wdata1});
    end

    task automatic model_step(input logic [15:0] d, input int c);
        bit q;
        int trail;
        q = m_key ? (d < cfg_thr_lo) : (d >= cfg_thr_hi);
        m_hist.push_back(q);
        trail = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (!m_hist[i]) break;
            trail++;
        end
        if (trail == int'(cfg_hold) + 1) begin
            exp_q.push_back('{c, {m_key, 31'(m_hist.size() - 1)}});
            m_key = !m_key;
            m_hist.delete();
            m_hist.push_back(1'b0);
        end
    endtask

    task automatic reset_all();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        obs0.delete();
        obs1.delete();
        exp_q.delete();
        m_hist.delete();
        m_key = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        s_axis_tdata = d;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        model_step(d, cyc);
    endtask

    task automatic test_reset();
        cfg_thr_hi = 16'd1000; cfg_thr_lo = 16'd500; cfg_hold = 16'd0;
        aresetn = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            total++;
            if (key0 !== 1'b0 || we0 !== 4'h0 || sts0 !== 10'd0 || tready0 !== 1'b0 || brst0 !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold: got key=%b we=%h sts=%0d tready=%b rst=%b, want 0 0 0 0 1",
                         key0, we0, sts0, tready0, brst0);
            end
        end
        aresetn = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        total++;
        if (tready0 !== 1'b1 || brst0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got tready=%b rst=%b, want 1 0", tready0, brst0);
        end
        $display("reset: tready=%b key=%b sts=%0d", tready0, key0, sts0);
    endtask

    task automatic test_basic(input bit gaps);
        logic [15:0] smp [12] = '{0, 0, 0, 0, 0, 1200, 1200, 1200, 100, 100, 100, 100};
        logic [31:0] lit [2]  = '{32'h0000_0005, 32'h8000_0003};
        reset_all();
        cfg_thr_hi = 16'd1000; cfg_thr_lo = 16'd500; cfg_hold = 16'd0;
        foreach (smp[i]) begin
            if (gaps) repeat ($urandom_range(0, 7)) @(negedge aclk);
            send(smp[i]);
            total++;
            if (key0 !== m_key || key0 !== ((i >= 5 && i <= 7) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL basic_key%0d: got %b want %b", i, key0, m_key);
            end
        end
        repeat (3) @(negedge aclk);
        total++;
        if (obs0.size() != 2 || sts0 !== 10'd2) begin
            bad++;
            $display("FAIL basic_count: got writes=%0d sts=%0d, want 2 2", obs0.size(), sts0);
        end
        for (int i = 0; i < 2 && i < obs0.size() && i < exp_q.size(); i++) begin
            total++;
            $display("basic gaps=%0d write: addr=%0d data=%h cyc=%0d", gaps, obs0[i].addr, obs0[i].data, obs0[i].cyc);
            if (obs0[i].addr !== 10'(i) || obs0[i].data !== lit[i] || obs0[i].cyc != exp_q[i].cyc) begin
                bad++;
                $display("FAIL basic_wr%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, obs0[i].addr, obs0[i].data, obs0[i].cyc, i, lit[i], exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_hysteresis();
        reset_all();
        cfg_thr_hi = 16'd1000; cfg_thr_lo = 16'd500; cfg_hold = 16'd0;
        send(16'd1200);
        for (int i = 0; i < 10; i++) begin
            send(16'd700);
            total++;
            if (key0 !== 1'b1) begin bad++; $display("FAIL hyst_key%0d: got %b want 1", i, key0); end
        end
        send(16'd400);
        total++;
        if (key0 !== 1'b0) begin bad++; $display("FAIL hyst_final_key: got %b want 0", key0); end
        repeat (2) @(negedge aclk);
        total++;
        if (obs0.size() != 2) begin
            bad++;
            $display("FAIL hyst_count: got %0d writes want 2", obs0.size());
        end else begin
            $display("hyst write: addr=%0d data=%h", obs0[1].addr, obs0[1].data);
            total++;
            if (obs0[1].data !== 32'h8000_000B || obs0[1].addr !== 10'd1 || obs0[0].data !== exp_q[0].data) begin
                bad++;
                $display("FAIL hyst_rec: got addr=%0d data=%h first=%h want 1 8000000b %h",
                         obs0[1].addr, obs0[1].data, obs0[0].data, exp_q[0].data);
            end
        end
    endtask

    task automatic test_debounce();
        logic [15:0] smp [10] = '{0, 0, 0, 0, 1200, 1200, 0, 1200, 1200, 1200};
        reset_all();
        cfg_thr_hi = 16'd1000; cfg_thr_lo = 16'd500; cfg_hold = 16'd2;
        foreach (smp[i]) begin
            send(smp[i]);
            total++;
            if (key0 !== ((i == 9) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL deb_key%0d: got %b want %b", i, key0, (i == 9));
            end
        end
        repeat (2) @(negedge aclk);
        total++;
        if (obs0.size() != 1 || exp_q.size() != 1) begin
            bad++;
            $display("FAIL deb_count: got %0d writes want 1", obs0.size());
        end else begin
            $display("debounce write: addr=%0d data=%h", obs0[0].addr, obs0[0].data);
            total++;
            if (obs0[0].data !== 32'h0000_0009 || obs0[0].cyc != exp_q[0].cyc) begin
                bad++;
                $display("FAIL deb_rec: got data=%h cyc=%0d want 00000009 cyc=%0d",
                         obs0[0].data, obs0[0].cyc, exp_q[0].cyc);
            end
        end
        cfg_hold = 16'd0;
    endtask

    task automatic test_back_to_back_wrap();
        reset_all();
        cfg_thr_hi = 16'd1000; cfg_thr_lo = 16'd500; cfg_hold = 16'd0;
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 16'd1200 : 16'd100);
        repeat (3) @(negedge aclk);
        total++;
        if (obs1.size() != 5 || sts1 !== 2'd1) begin
            bad++;
            $display("FAIL wrap_count: got writes=%0d sts=%0d want 5 1", obs1.size(), sts1);
        end
        for (int i = 0; i < 5 && i < obs1.size() && i < exp_q.size(); i++) begin
            total++;
            $display("wrap write: addr=%0d data=%h cyc=%0d", obs1[i].addr, obs1[i].data, obs1[i].cyc);
            if (obs1[i].addr !== 10'(i % 4) || obs1[i].data !== exp_q[i].data || obs1[i].cyc != exp_q[i].cyc
                || (i > 0 && obs1[i].cyc != obs1[i-1].cyc + 1)) begin
                bad++;
                $display("FAIL wrap_wr%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, obs1[i].addr, obs1[i].data, obs1[i].cyc, i % 4, exp_q[i].data, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        reset_all();
        cfg_thr_hi = 16'($urandom_range(600, 3000));
        cfg_thr_lo = 16'($urandom_range(100, int'(cfg_thr_hi)));
        cfg_hold   = 16'($urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge aclk);
            send(16'($urandom_range(0, 4000)));
            total++;
            if (key0 !== m_key) begin
                bad++;
                $display("FAIL rand_key%0d: got %b want %b", i, key0, m_key);
            end
        end
        repeat (3) @(negedge aclk);
        total++;
        if (obs0.size() != exp_q.size() || sts0 !== 10'(exp_q.size())) begin
            bad++;
            $display("FAIL rand_count: got writes=%0d sts=%0d want %0d", obs0.size(), sts0, exp_q.size());
        end
        for (int i = 0; i < obs0.size() && i < exp_q.size(); i++) begin
            total++;
            $display("random write: addr=%0d data=%h cyc=%0d", obs0[i].addr, obs0[i].data, obs0[i].cyc);
            if (obs0[i].addr !== 10'(i) || obs0[i].data !== exp_q[i].data || obs0[i].cyc != exp_q[i].cyc) begin
                bad++;
                $display("FAIL rand_wr%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, obs0[i].addr, obs0[i].data, obs0[i].cyc, i, exp_q[i].data, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_midreset();
        reset_all();
        cfg_thr_hi = 16'd1000; cfg_thr_lo = 16'd500; cfg_hold = 16'd0;
        repeat (3) send(16'd0);
        repeat (3) send(16'd1200);
        // A transitioning sample arriving together with reset must leave no trace.
        s_axis_tdata = 16'd100;
        s_axis_tvalid = 1'b1;
        aresetn = 1'b0;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        total++;
        if (key0 !== 1'b0 || we0 !== 4'h0 || sts0 !== 10'd0 || obs0.size() != 1) begin
            bad++;
            $display("FAIL midrst_state: got key=%b we=%h sts=%0d writes=%0d want 0 0 0 1",
                     key0, we0, sts0, obs0.size());
        end
        reset_all();
        send(16'd0);
        send(16'd0);
        send(16'd1200);
        repeat (2) @(negedge aclk);
        total++;
        if (obs0.size() != 1) begin
            bad++;
            $display("FAIL midrst_count: got %0d writes want 1", obs0.size());
        end else begin
            $display("midreset write: addr=%0d data=%h", obs0[0].addr, obs0[0].data);
            total++;
            if (obs0[0].addr !== 10'd0 || obs0[0].data !== 32'h0000_0002) begin
                bad++;
                $display("FAIL midrst_rec: got addr=%0d data=%h want 0 00000002", obs0[0].addr, obs0[0].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_hysteresis();
        test_debounce();
        test_back_to_back_wrap();
        test_basic(1'b1);
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
